// File: rtl/mat_pkg.sv
// Shared constants, state encoding and row helper for the matrix transform sequencer.
package mat_pkg;

    localparam int DATA_W    = 16;
    localparam int MAT_DIM   = 3;
    localparam int N_ENTRIES = 9;
    localparam int ADDR_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Row of a row-major entry index (idx / 3); written as compares to stay a tiny mux.
    function automatic logic [1:0] row_of(input logic [ADDR_W-1:0] idx);
        if (idx < 4'd3) begin
            return 2'd0;
        end else if (idx < 4'd6) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

endpackage

// File: rtl/mat_xform_sequencer_scale_add_pipe.sv
// Two-stage scale-then-translate pipe: stage 1 multiplies, stage 2 adds and flags overflow.
module scale_add_pipe
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_tag,
    input  logic [DATA_W-1:0] scale,
    input  logic [DATA_W-1:0] operand,
    input  logic [DATA_W-1:0] trans,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_tag,
    output logic [DATA_W-1:0] result,
    output logic              rsp_ovf
);

    logic                mul_valid;
    logic [ADDR_W-1:0]   mul_tag;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   mul_trans;
    logic [2*DATA_W:0]   sum;

    // Full-width sum keeps the carry so overflow past DATA_W bits is visible.
    assign sum = {1'b0, prod} + {{(DATA_W+1){1'b0}}, mul_trans};

    // Stage 1: register the full product along with its tag and translation term.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_valid <= 1'b0;
            mul_tag   <= '0;
            prod      <= '0;
            mul_trans <= '0;
        end else begin
            mul_valid <= req_valid;
            if (req_valid) begin
                mul_tag   <= req_tag;
                prod      <= {{DATA_W{1'b0}}, scale} * {{DATA_W{1'b0}}, operand};
                mul_trans <= trans;
            end
        end
    end

    // Stage 2: register the truncated sum and whether any upper bit was lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_tag   <= '0;
            result    <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            rsp_valid <= mul_valid;
            rsp_ovf   <= mul_valid && (sum[2*DATA_W:DATA_W] != '0);
            if (mul_valid) begin
                rsp_tag <= mul_tag;
                result  <= sum[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mat_xform_sequencer.sv
// Walks the 3x3 origin matrix through one shared scale/add pipe and writes the modified matrix.
module mat_xform_sequencer
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] scale_x,
    input  logic [DATA_W-1:0] scale_y,
    input  logic [DATA_W-1:0] scale_z,
    input  logic [DATA_W-1:0] trans_x,
    input  logic [DATA_W-1:0] trans_y,
    input  logic [DATA_W-1:0] trans_z,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              issue;
    logic [DATA_W-1:0] scale_snap [MAT_DIM];
    logic [DATA_W-1:0] trans_snap [MAT_DIM];
    logic [DATA_W-1:0] cur_scale;
    logic [DATA_W-1:0] cur_trans;
    logic              rsp_valid;
    logic              rsp_ovf;
    logic              ovf_hold;

    // Next state plus the state-decoded outputs; idx doubles as the drain counter.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        rd_addr    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                issue   = 1'b1;
                busy    = 1'b1;
                rd_addr = idx;
                if (idx == 4'd8) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (idx == 4'd1) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; reset wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Entry counter during ISSUE, reused to time the two drain cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (state == IDLE || state == DONE || (state == ISSUE && idx == 4'd8)) begin
            idx <= '0;
        end else begin
            idx <= idx + 4'd1;
        end
    end

    // Snapshot the transform parameters when a pass is accepted so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < MAT_DIM; r++) begin
                scale_snap[r] <= '0;
                trans_snap[r] <= '0;
            end
        end else if (accept) begin
            scale_snap[0] <= scale_x;
            scale_snap[1] <= scale_y;
            scale_snap[2] <= scale_z;
            trans_snap[0] <= trans_x;
            trans_snap[1] <= trans_y;
            trans_snap[2] <= trans_z;
        end
    end

    // Pick the snapshot row that matches the entry being issued.
    always_comb begin
        cur_scale = scale_snap[2];
        cur_trans = trans_snap[2];
        case (row_of(idx))
            2'd0: begin
                cur_scale = scale_snap[0];
                cur_trans = trans_snap[0];
            end
            2'd1: begin
                cur_scale = scale_snap[1];
                cur_trans = trans_snap[1];
            end
            default: begin
                cur_scale = scale_snap[2];
                cur_trans = trans_snap[2];
            end
        endcase
    end

    scale_add_pipe u_pipe (
        .clk       (clk),
        .rst       (rst),
        .req_valid (issue),
        .req_tag   (idx),
        .scale     (cur_scale),
        .operand   (rd_data),
        .trans     (cur_trans),
        .rsp_valid (rsp_valid),
        .rsp_tag   (wr_addr),
        .result    (wr_data),
        .rsp_ovf   (rsp_ovf)
    );

    assign wr_en = rsp_valid;

    // ovf must rise with the offending write, so the live flag is ORed onto the held value.
    assign ovf = ovf_hold | (rsp_valid & rsp_ovf);

    // Sticky overflow, cleared by reset or by accepting a new pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_hold <= 1'b0;
        end else if (accept) begin
            ovf_hold <= 1'b0;
        end else begin
            ovf_hold <= ovf;
        end
    end

endmodule

// File: tb/tb_mat_xform_sequencer.sv
// Self-checking bench: directed and randomized passes compared with a per-entry arithmetic model.
module tb_mat_xform_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] scale_x, scale_y, scale_z;
    logic [15:0] trans_x, trans_y, trans_z;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        ovf;

    logic [15:0] origin [9];
    logic [15:0] refScale [3];
    logic [15:0] refTrans [3];
    logic [15:0] expData [9];
    bit          expOvf [9];

    int checkCount = 0;
    int passCount  = 0;

    mat_xform_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .scale_x (scale_x),
        .scale_y (scale_y),
        .scale_z (scale_z),
        .trans_x (trans_x),
        .trans_y (trans_y),
        .trans_z (trans_z),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    // Origin matrix with a same-cycle read port.
    assign rd_data = (rd_addr < 4'd9) ? origin[rd_addr] : 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] sx, input logic [15:0] sy, input logic [15:0] sz,
                                 input logic [15:0] tx, input logic [15:0] ty, input logic [15:0] tz);
        scale_x = sx; scale_y = sy; scale_z = sz;
        trans_x = tx; trans_y = ty; trans_z = tz;
    endtask

    // Reference result for each entry: scale of its row times the entry plus the row translation.
    task automatic buildModel();
        longint s;
        refScale[0] = scale_x; refScale[1] = scale_y; refScale[2] = scale_z;
        refTrans[0] = trans_x; refTrans[1] = trans_y; refTrans[2] = trans_z;
        for (int k = 0; k < 9; k++) begin
            s = longint'(refScale[k / 3]) * longint'(origin[k]) + longint'(refTrans[k / 3]);
            expData[k] = s[15:0];
            expOvf[k]  = (s >> 16) != 0;
        end
    endtask

    // One pass started in the current cycle T; checks every cycle up to T+14.
    task automatic runPass(input bit perturb, input int rstAt);
        bit sticky;
        bit live;
        sticky = 1'b0;
        @(posedge clk); #1;
        buildModel();
        start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (perturb && i == 2) applyStimulus(16'd9, 16'd9, 16'd9, 16'd99, 16'd99, 16'd99);
            if (perturb && (i == 5 || i == 12)) start = 1'b1;
            rst = (rstAt != 0 && i == rstAt);
            @(negedge clk);
            live = (rstAt == 0) || (i <= rstAt);
            if (live && i >= 3 && i <= 11 && expOvf[i-3]) sticky = 1'b1;
            checkOutput($sformatf("busy@T+%0d", i), 32'(busy), 32'(live && i <= 11));
            checkOutput($sformatf("done@T+%0d", i), 32'(done), 32'(live && i == 12));
            checkOutput($sformatf("rd_addr@T+%0d", i), 32'(rd_addr), (live && i <= 9) ? i - 1 : 0);
            checkOutput($sformatf("wr_en@T+%0d", i), 32'(wr_en), 32'(live && i >= 3 && i <= 11));
            if (live && i >= 3 && i <= 11) begin
                checkOutput($sformatf("wr_addr@T+%0d", i), 32'(wr_addr), i - 3);
                checkOutput($sformatf("wr_data@T+%0d", i), 32'(wr_data), 32'(expData[i-3]));
            end
            checkOutput($sformatf("ovf@T+%0d", i), 32'(ovf), 32'(live && sticky));
        end
        rst   = 1'b0;
        start = 1'b0;
    endtask

    // start held high: passes must chain every 13 cycles with nine writes each.
    task automatic runBackToBack();
        int sinceDone;
        int doneCount;
        int ph;
        sinceDone = 0;
        doneCount = 0;
        @(posedge clk); #1;
        buildModel();
        start = 1'b1;
        for (int i = 1; i <= 38; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            ph = i % 13;
            checkOutput($sformatf("b2b_done@T+%0d", i), 32'(done), 32'(ph == 12));
            checkOutput($sformatf("b2b_wr_en@T+%0d", i), 32'(wr_en), 32'(ph >= 3 && ph <= 11));
            if (ph >= 3 && ph <= 11) begin
                checkOutput($sformatf("b2b_wr_addr@T+%0d", i), 32'(wr_addr), ph - 3);
                checkOutput($sformatf("b2b_wr_data@T+%0d", i), 32'(wr_data), 32'(expData[ph-3]));
            end
            if (wr_en) sinceDone++;
            if (done) begin
                checkOutput($sformatf("b2b_writes@T+%0d", i), sinceDone, 9);
                sinceDone = 0;
                doneCount++;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("b2b_done_count", doneCount, 3);
        @(negedge clk);
        checkOutput("b2b_idle_busy", 32'(busy), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        applyStimulus(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        for (int k = 0; k < 9; k++) origin[k] = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_wr_en", 32'(wr_en), 0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 0);
        checkOutput("reset_wr_data", 32'(wr_data), 0);
        checkOutput("reset_rd_addr", 32'(rd_addr), 0);
        checkOutput("reset_ovf", 32'(ovf), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic pass: expected writes 12,14,16,32,35,38,58,62,66.
        for (int k = 0; k < 9; k++) origin[k] = 16'(k + 1);
        applyStimulus(16'd2, 16'd3, 16'd4, 16'd10, 16'd20, 16'd30);
        runPass(1'b0, 0);

        // Overflow on entry 4 only: 2*FFFF+1 = 1FFFF truncates to FFFF.
        for (int k = 0; k < 9; k++) origin[k] = 16'd0;
        origin[4] = 16'hFFFF;
        applyStimulus(16'd0, 16'd2, 16'd0, 16'd0, 16'd1, 16'd0);
        runPass(1'b0, 0);

        // Inputs change and start re-pulses mid-pass and in DONE; snapshot must rule.
        for (int k = 0; k < 9; k++) origin[k] = 16'(k + 1);
        applyStimulus(16'd2, 16'd3, 16'd4, 16'd10, 16'd20, 16'd30);
        runPass(1'b1, 0);

        // Reset during the pass after three writes, with ovf already raised by entry 0.
        for (int k = 0; k < 9; k++) origin[k] = 16'($urandom);
        origin[0] = 16'hFFFF;
        applyStimulus(16'hFFFF, 16'd5, 16'd7, 16'd3, 16'd4, 16'd5);
        runPass(1'b0, 5);

        // Fresh pass after reset completes normally with ovf clear.
        for (int k = 0; k < 9; k++) origin[k] = 16'(k + 1);
        applyStimulus(16'd2, 16'd3, 16'd4, 16'd10, 16'd20, 16'd30);
        runPass(1'b0, 0);

        // Randomized passes mixing small and large factors.
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 9; k++) origin[k] = 16'($urandom);
            applyStimulus(16'($urandom >> $urandom_range(16, 31)), 16'($urandom >> $urandom_range(16, 31)),
                          16'($urandom >> $urandom_range(16, 31)), 16'($urandom), 16'($urandom),
                          16'($urandom >> $urandom_range(16, 31)));
            runPass(1'b0, 0);
        end

        // Back-to-back passes with start held high.
        for (int k = 0; k < 9; k++) origin[k] = 16'($urandom_range(0, 1000));
        applyStimulus(16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17);
        runBackToBack();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
